mem_arbiter: RTL

Arbiter between the instruction cache and the data cache for the single-ported RAM. It grants one requester at a time and holds that grant until the RAM completes the transaction. Data-side requests have priority, and a starvation counter bounds how long instruction fetch can be held off. It sits between the cache pair and the RAM model, inside the memory-control level of the CPU.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-ported RAM to either the icache or the dcache.
// Data side wins ties, except that an instruction fetch waiting behind
// STARVE_LIMIT consecutive data grants is served next. A grant is held until
// the RAM reports ACCESS or the granted requester drops its request.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  // icache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // dcache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } ram_req_t;

  state_t          state;
  logic [SW-1:0]   scnt;
  logic            dreq;
  logic            acc;
  ram_req_t        req;

  assign dreq = dREN | dWEN;
  assign acc  = (ramstate == RS_ACCESS);

  // Load data is passed straight through; requesters only look while wait is 0.
  assign iload = ramload;
  assign dload = ramload;

  assign ramREN   = req.ren;
  assign ramWEN   = req.wen;
  assign ramaddr  = req.addr;
  assign ramstore = req.store;

  // RAM strobes and wait pulses follow the grant state and the live request,
  // so a dropped request releases the RAM in the same cycle and reset clears
  // everything asynchronously through the state register.
  always_comb begin
    req   = '0;
    iwait = 1'b1;
    dwait = 1'b1;
    case (state)
      IGNT: begin
        req.ren  = iREN;
        req.addr = iaddr;
        iwait    = !(iREN && acc);
      end
      DGNT: begin
        // dREN together with dWEN is treated as a write
        req.wen   = dWEN;
        req.ren   = dREN & ~dWEN;
        req.addr  = daddr;
        req.store = dstore;
        dwait     = !(dreq && acc);
      end
      default: ;
    endcase
  end

  // Grant FSM, starvation counter and sticky error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      scnt  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !(iREN && scnt == LIMIT)) begin
            state <= DGNT;
            // only reached with iREN high while scnt < LIMIT, so no overflow
            scnt  <= iREN ? scnt + 1'b1 : '0;
          end else if (iREN) begin
            state <= IGNT;
            scnt  <= '0;
          end
        end
        IGNT: begin
          if (ramstate == RS_ERROR) err <= 1'b1;
          if (!iREN || acc) state <= IDLE;
        end
        DGNT: begin
          if (ramstate == RS_ERROR || (dREN && dWEN)) err <= 1'b1;
          if (!dreq || acc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
